// File: rtl/mem_access_unit.sv
// Load/store front end: byte/half/word requests to a word-addressed data_memory,
// with read-modify-write for sub-word stores. Optional macro: MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writeData,
  output logic                  mem_memWrite,
  output logic                  mem_memRead,
  input  logic [DATA_WIDTH-1:0] mem_readData
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, RESP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              lane_q, lane_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic                    write_q, write_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_error_q, resp_error_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    mem_re_q, mem_re_d;

  logic [ADDR_WIDTH-1:0]   addr_eff;
  logic                    misaligned;

  // Lane shift to bit 0, then extend; word accesses bypass the lane logic.
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] word, input logic [1:0] size,
    input logic [1:0] lane, input logic sgn);
    logic [DATA_WIDTH-1:0] sh;
    sh = word >> {lane, 3'b000};
    if (size[1]) return word;
    if (size[0]) return {{16{sgn & sh[15]}}, sh[15:0]};
    return {{24{sgn & sh[7]}}, sh[7:0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word, input logic [1:0] size,
    input logic [1:0] lane, input logic [15:0] wdata);
    logic [DATA_WIDTH-1:0] mask, ins;
    mask = size[0] ? 32'h0000_FFFF : 32'h0000_00FF;
    ins  = {16'h0000, wdata} & mask;
    return (word & ~(mask << {lane, 3'b000})) | (ins << {lane, 3'b000});
  endfunction

  always_comb begin
    addr_eff = req_addr;
`ifdef MISALIGN_TRAP_EN
    misaligned = (req_size[1] && (req_addr[1:0] != 2'b00)) ||
                 (req_size == 2'b01 && req_addr[0]);
`else
    misaligned = 1'b0;
    if (req_size[1])      addr_eff[1:0] = 2'b00;
    else if (req_size[0]) addr_eff[0]   = 1'b0;
`endif
  end

  // NOTE: every _d gets a default hold/clear first, so no path leaves a latch.
  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    size_d        = size_q;
    signed_d      = signed_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    resp_rdata_d  = '0;
    resp_error_d  = 1'b0;

    case (state_q)
      IDLE: if (req_valid) begin
        lane_d        = addr_eff[1:0];
        size_d        = req_size;
        signed_d      = req_signed;
        write_d       = req_write;
        wdata_d       = req_wdata[15:0];
        mem_address_d = addr_eff >> 2;
        if (misaligned) begin
          state_d      = RESP;
          resp_error_d = 1'b1;
        end else if (req_write && req_size[1]) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = req_wdata;
        end else begin
          state_d  = READ;
          mem_re_d = 1'b1;
        end
      end
      READ: state_d = CAPT;
      CAPT: if (write_q) begin
        state_d     = WRITE;
        mem_we_d    = 1'b1;
        mem_wdata_d = store_merge(mem_readData, size_q, lane_q, wdata_q);
      end else begin
        state_d      = RESP;
        resp_rdata_d = load_extract(mem_readData, size_q, lane_q, signed_q);
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    resp_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      lane_q        <= '0;
      size_q        <= '0;
      signed_q      <= 1'b0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_error_q  <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      size_q        <= size_d;
      signed_q      <= signed_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_error    = resp_error_q;
  assign mem_address   = mem_address_q;
  assign mem_writeData = mem_wdata_q;
  assign mem_memWrite  = mem_we_q;
  assign mem_memRead   = mem_re_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-lane reference model and
// a 16-word data_memory stand-in (synchronous read, falling-edge write).
module tb_mem_access_unit;

  logic        clock_in = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_writeData;
  logic        mem_memWrite, mem_memRead;
  logic [31:0] mem_readData = '0;

  logic [31:0] mem [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock_in(clock_in), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_address(mem_address),
    .mem_writeData(mem_writeData), .mem_memWrite(mem_memWrite),
    .mem_memRead(mem_memRead), .mem_readData(mem_readData)
  );

  always #5 clock_in = ~clock_in;

  always @(negedge clock_in) if (mem_memWrite) mem[mem_address[3:0]] <= mem_writeData;
  always @(posedge clock_in) if (mem_memRead) mem_readData <= mem[mem_address[3:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"},  {31'b0, req_ready},    32'd1);
    check({tag, "_rvalid"}, {31'b0, resp_valid},   32'd0);
    check({tag, "_rdata"},  resp_rdata,            32'd0);
    check({tag, "_rerr"},   {31'b0, resp_error},   32'd0);
    check({tag, "_we"},     {31'b0, mem_memWrite}, 32'd0);
    check({tag, "_re"},     {31'b0, mem_memRead},  32'd0);
  endtask

  // Entered and left at posedge+1 with the unit idle.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata_o);
    logic [31:0] eff, exp_rdata, new_word, wa, wdat;
    logic        mis, both;
    logic [7:0]  b [4];
    int          lane, exp_lat, exp_rd, exp_wr, lat, rd_cnt, wr_cnt;

    eff = addr; mis = 1'b0;
    if (sz == 2'b01 && addr[0]) begin
`ifdef MISALIGN_TRAP_EN
      mis = 1'b1;
`else
      eff[0] = 1'b0;
`endif
    end
    if (sz[1] && addr[1:0] != 2'b00) begin
`ifdef MISALIGN_TRAP_EN
      mis = 1'b1;
`else
      eff[1:0] = 2'b00;
`endif
    end
    lane = int'(eff[1:0]);
    for (int i = 0; i < 4; i++) b[i] = ref_mem[eff[5:2]][8*i +: 8];
    exp_rdata = 32'h0;
    if (mis) begin
      exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (!wr) begin
      exp_lat = 3; exp_rd = 1; exp_wr = 0;
      case (sz)
        2'b00:   exp_rdata = {{24{sg & b[lane][7]}}, b[lane]};
        2'b01:   exp_rdata = {{16{sg & b[lane+1][7]}}, b[lane+1], b[lane]};
        default: exp_rdata = {b[3], b[2], b[1], b[0]};
      endcase
    end else if (sz[1]) begin
      exp_lat = 2; exp_rd = 0; exp_wr = 1;
      {b[3], b[2], b[1], b[0]} = wd;
    end else begin
      exp_lat = 4; exp_rd = 1; exp_wr = 1;
      b[lane] = wd[7:0];
      if (sz[0]) b[lane+1] = wd[15:8];
    end
    new_word = {b[3], b[2], b[1], b[0]};

    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clock_in); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;

    lat = 1; rd_cnt = 0; wr_cnt = 0; both = 1'b0; wa = '0; wdat = '0;
    forever begin
      if (mem_memRead) rd_cnt++;
      if (mem_memWrite) begin wr_cnt++; wa = mem_address; wdat = mem_writeData; end
      if (mem_memRead && mem_memWrite) both = 1'b1;
      if (resp_valid || lat >= 12) break;
      @(posedge clock_in); #1;
      lat++;
    end
    rdata_o = resp_rdata;
    check("latency",   lat,    exp_lat);
    check("resp_valid",{31'b0, resp_valid}, 32'd1);
    check("resp_rdata", resp_rdata, exp_rdata);
    check("resp_error",{31'b0, resp_error}, {31'b0, mis});
    check("rd_strobes", rd_cnt, exp_rd);
    check("wr_strobes", wr_cnt, exp_wr);
    check("strobe_excl", {31'b0, both}, 32'd0);
    if (exp_wr == 1) begin
      check("wr_addr", wa, eff >> 2);
      check("wr_data", wdat, new_word);
      ref_mem[eff[5:2]] = new_word;
    end
    @(posedge clock_in); #1;
    check_quiet("post");
  endtask

  logic [31:0] r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    #1;
    check_quiet("rst");
    check("rst_addr",  mem_address,   32'd0);
    check("rst_wdata", mem_writeData, 32'd0);
    repeat (2) @(posedge clock_in);
    @(negedge clock_in) reset = 1'b1;
    @(posedge clock_in); #1;

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, r);
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, r);  check("tp_lb_s",  r, 32'hFFFFFFDE);
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, r);  check("tp_lb_u",  r, 32'h000000DE);
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, r);  check("tp_lh_u",  r, 32'h0000DEAD);
    do_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, r);  check("tp_lh_s",  r, 32'hFFFFBEEF);
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h55, r);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, r);  check("tp_lw",    r, 32'hDEAD55EF);
    do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, r);
    do_req(1'b0, 2'b01, 1'b0, 32'h15, 32'h0, r);
`ifdef MISALIGN_TRAP_EN
    check("tp_mis", r, 32'h0);
`else
    check("tp_mis", r, 32'h0000F00D);
`endif

    // Reset during CAPT of a sub-word store aborts it without a write.
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, r);
    req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'hAA; req_valid = 1'b1;
    @(posedge clock_in); #1; req_valid = 1'b0;
    check("abort_read", {31'b0, mem_memRead}, 32'd1);
    @(posedge clock_in); #2;
    reset = 1'b0; #1;
    check_quiet("abort");
    check("abort_addr", mem_address, 32'd0);
    @(posedge clock_in); #1;
    check_quiet("abort_hold");
    @(negedge clock_in) reset = 1'b1;
    @(posedge clock_in); #1;
    check("abort_mem", mem[8], 32'h12345678);
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, r);  check("after_abort", r, 32'h12345678);

    for (int k = 0; k < 16; k++) do_req(1'b1, 2'b10, 1'b0, 32'(4 * k), $urandom, r);
    for (int k = 0; k < 250; k++)
      do_req(1'($urandom), 2'($urandom), 1'($urandom),
             32'($urandom_range(0, 63)), $urandom, r);

    for (int i = 0; i < 16; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
